// File: rtl/sigmoid_pwl_if.sv
// Streaming interface of the sigmoid unit: one input channel, one output channel.
//
// Handshake: a word moves on a channel at the rising clk edge where both
// valid and ready are high. The producer holds its data and valid stable until
// that edge, and valid never waits on ready.
interface sigmoid_pwl_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] sig_in;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sig_out;

    // Sample source / result sink side
    modport master (
        output in_valid,
        output sig_in,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sig_out
    );

    // Sigmoid unit side
    modport slave (
        input  in_valid,
        input  sig_in,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sig_out
    );
endinterface

// File: rtl/sigmoid_pwl.sv
// Three-stage piecewise-linear (PLAN) sigmoid with a hard-step bypass mode.
// Stage 1 takes sign and magnitude, stage 2 evaluates the segment for |x|,
// stage 3 mirrors the result for negative inputs. A single global enable
// stalls the whole pipe when the output is held, so in_ready is simply en.
module sigmoid_pwl #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    sigmoid_pwl_if.slave   bus
);

    // Fixed-point constants, all in the FRAC_W scale. Fractions that need
    // more bits than FRAC_W provides are truncated towards zero.
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(64'd1 << FRAC_W);
    localparam logic [DATA_W-1:0] HALF    = DATA_W'(64'd1 << (FRAC_W - 1));
    localparam logic [DATA_W-1:0] FIVE    = DATA_W'(64'd5 << FRAC_W);
    localparam logic [DATA_W-1:0] T_2375  = DATA_W'((64'd19 << FRAC_W) >> 3);
    localparam logic [DATA_W-1:0] C_84375 = DATA_W'((64'd27 << FRAC_W) >> 5);
    localparam logic [DATA_W-1:0] C_625   = DATA_W'((64'd5 << FRAC_W) >> 3);
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic              en;

    // Stage 1: sign, mode, magnitude
    logic              v1;
    logic              s1;
    logic              m1;
    logic [DATA_W-1:0] a1;

    // Stage 2: sign and positive-half result p (mode is resolved here)
    logic              v2;
    logic              s2;
    logic [DATA_W-1:0] p2;

    // Stage 3: final result
    logic              v3;
    logic [DATA_W-1:0] y3;

    logic [DATA_W-1:0] abs_x;
    logic [DATA_W-1:0] p_next;
    logic [DATA_W-1:0] y_next;

    assign en            = !v3 || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = v3;
    assign bus.sig_out   = y3;

    // Magnitude of x; the most-negative code has no positive twin and saturates
    always_comb begin
        abs_x = bus.sig_in;
        if (bus.sig_in[DATA_W-1]) begin
            if (bus.sig_in == MIN_NEG) begin
                abs_x = MAX_POS;
            end else begin
                abs_x = -bus.sig_in;
            end
        end
    end

    // Segment evaluation for |x|; hard-step mode forces p to 1.0 so that the
    // sign mirror in stage 3 yields 1.0 for x >= 0 and 0 for x < 0
    always_comb begin
        p_next = ONE;
        if (!m1) begin
            if (a1 >= FIVE) begin
                p_next = ONE;
            end else if (a1 >= T_2375) begin
                p_next = (a1 >> 5) + C_84375;
            end else if (a1 >= ONE) begin
                p_next = (a1 >> 3) + C_625;
            end else begin
                p_next = (a1 >> 2) + HALF;
            end
        end
    end

    // Mirror around 0.5 for negative inputs; p never exceeds 1.0 so no underflow
    always_comb begin
        y_next = p2;
        if (s2) begin
            y_next = ONE - p2;
        end
    end

    // Pipeline registers; every stage moves together under the global enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            s1 <= 1'b0;
            m1 <= 1'b0;
            a1 <= '0;
            v2 <= 1'b0;
            s2 <= 1'b0;
            p2 <= '0;
            v3 <= 1'b0;
            y3 <= '0;
        end else if (en) begin
            v1 <= bus.in_valid;
            s1 <= bus.sig_in[DATA_W-1];
            m1 <= bus.mode;
            a1 <= abs_x;
            v2 <= v1;
            s2 <= s1;
            p2 <= p_next;
            v3 <= v2;
            y3 <= y_next;
        end
    end

endmodule

// File: tb/tb_sigmoid_pwl.sv
// Directed and randomised bench for sigmoid_pwl at DATA_W=16, FRAC_W=8.
module tb_sigmoid_pwl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;

    sigmoid_pwl_if #(.DATA_W(W)) bus();

    sigmoid_pwl #(.DATA_W(W), .FRAC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int           n_xfer = 0;
    logic [W-1:0] exp_q[$];
    bit           hold_pending = 1'b0;
    logic [W-1:0] held = '0;
    bit           sweep_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference sigmoid for the random sweep (integer arithmetic in 1/256 units)
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic m);
        int xi;
        int a;
        int p;
        bit neg;
        xi  = int'($signed(x));
        neg = x[W-1];
        if (m) return neg ? 16'h0000 : 16'h0100;
        a = neg ? -xi : xi;
        if (a > 32767) a = 32767;
        if (a >= 1280)     p = 256;
        else if (a >= 608) p = a / 32 + 216;
        else if (a >= 256) p = a / 8 + 160;
        else               p = a / 4 + 128;
        return 16'(neg ? 256 - p : p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample and wait for its acceptance; leaves in_valid high
    task automatic send(input logic [W-1:0] x, input logic m, input logic [W-1:0] exp,
                        output int waited);
        bus.in_valid = 1'b1;
        bus.sig_in   = x;
        bus.mode     = m;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready) exp_q.push_back(exp);
        else check("send_timeout", 32'(waited), 32'd0);
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard and output-protocol monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_data", 32'(bus.sig_out), 32'(held));
                end
                check("in_ready_en", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
                check("out_le_one", 32'(bus.sig_out > 16'h0100), 32'd0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
                    else check("data", 32'(bus.sig_out), 32'(exp_q.pop_front()));
                    n_xfer++;
                end
                hold_pending = bus.out_valid && !bus.out_ready;
                held         = bus.sig_out;
            end
        end
    end

    // Directed sequence
    initial begin
        int w;
        int n0;
        bus.in_valid  = 1'b0;
        bus.sig_in    = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sig_out", 32'(bus.sig_out), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) step();
        reset = 1'b1;

        // First sample right after release, with latency check
        send(16'h0000, 1'b0, 16'h0080, w);
        bus.in_valid = 1'b0;
        check("first_accept_wait", 32'(w), 32'd0);
        @(negedge clk); check("lat_c1", 32'(bus.out_valid), 32'd0);
        @(negedge clk); check("lat_c2", 32'(bus.out_valid), 32'd0);
        @(negedge clk); check("lat_c3", 32'(bus.out_valid), 32'd1);
        step();

        // Back-to-back positive stream followed by a bubble
        send(16'h0000, 1'b0, 16'h0080, w);
        send(16'h0080, 1'b0, 16'h00A0, w);
        send(16'h0100, 1'b0, 16'h00C0, w);
        send(16'h0300, 1'b0, 16'h00F0, w);
        send(16'h0500, 1'b0, 16'h0100, w);
        bus.in_valid = 1'b0;
        @(negedge clk); check("b2b_1", 32'(bus.out_valid), 32'd1);
        @(negedge clk); check("b2b_2", 32'(bus.out_valid), 32'd1);
        @(negedge clk); check("b2b_3", 32'(bus.out_valid), 32'd1);
        @(negedge clk); check("bubble", 32'(bus.out_valid), 32'd0);
        step();

        // Negative input and saturation extremes
        send(16'hFF00, 1'b0, 16'h0040, w);
        send(16'h8000, 1'b0, 16'h0000, w);
        send(16'h7FFF, 1'b0, 16'h0100, w);
        drain();

        // Hard-step mode, then interleaved modes
        send(16'h0000, 1'b1, 16'h0100, w);
        send(16'hFFFF, 1'b1, 16'h0000, w);
        send(16'h1234, 1'b1, 16'h0100, w);
        send(16'h0100, 1'b0, 16'h00C0, w);
        send(16'h0100, 1'b1, 16'h0100, w);
        send(16'hFF00, 1'b0, 16'h0040, w);
        send(16'hFF00, 1'b1, 16'h0000, w);
        send(16'h8000, 1'b1, 16'h0000, w);
        drain();

        // Eight samples under pseudo-random back-pressure
        n0 = n_xfer;
        fork
            begin
                send(16'h0000, 1'b0, 16'h0080, w);
                send(16'h00FF, 1'b0, 16'h00BF, w);
                send(16'h0260, 1'b0, 16'h00EB, w);
                send(16'h04FF, 1'b0, 16'h00FF, w);
                send(16'hFD00, 1'b0, 16'h0010, w);
                send(16'h0500, 1'b0, 16'h0100, w);
                send(16'hFF80, 1'b0, 16'h0060, w);
                send(16'h1234, 1'b1, 16'h0100, w);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (40) begin
                    step();
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", 32'(n_xfer - n0), 32'd8);

        // Reset with three samples stalled in the pipe
        bus.out_ready = 1'b0;
        send(16'h0500, 1'b0, 16'h0100, w);
        send(16'h0300, 1'b0, 16'h00F0, w);
        send(16'hFF00, 1'b0, 16'h0040, w);
        bus.in_valid = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sig_out", 32'(bus.sig_out), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        step();
        step();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        send(16'h0000, 1'b0, 16'h0080, w);
        bus.in_valid = 1'b0;
        check("postrst_accept_wait", 32'(w), 32'd0);
        @(negedge clk); check("postrst_c1", 32'(bus.out_valid), 32'd0);
        @(negedge clk); check("postrst_c2", 32'(bus.out_valid), 32'd0);
        @(negedge clk); check("postrst_c3", 32'(bus.out_valid), 32'd1);
        step();
        drain();

        // Random sweep of input codes and modes against the reference model
        fork
            begin
                logic [W-1:0] x;
                logic         m;
                for (int i = 0; i < 300; i++) begin
                    x = 16'($urandom_range(0, 65535));
                    m = ($urandom_range(0, 3) == 0);
                    send(x, m, model(x, m), w);
                end
                bus.in_valid = 1'b0;
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    step();
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
